// File: rtl/alarma_seq.sv
// ---------------------------------------------------------------------------
// alarma_seq -- sequential car-alarm controller
//
// Watches NDOORS door/boot/bonnet contacts, a motion sensor and the ignition
// key contact. It adds remote arm/disarm, a timed exit delay before arming,
// a timed entry delay before the siren sounds, a timed siren and an
// alarm-memory flag. One instance sits between the sensors of a vehicle and
// its siren driver.
//
// Parameters
//   NDOORS      number of door contact inputs (>= 1)
//   EXIT_DELAY  cycles spent in EXIT before the system is armed (>= 1)
//   ENTRY_DELAY cycles allowed in ENTRY before the siren sounds (>= 1)
//   SIREN_TIME  cycles the siren stays on per alarm event (>= 1)
//   CW          timer width, 2^CW > max(EXIT_DELAY, ENTRY_DELAY, SIREN_TIME)
//
// Ports
//   clk     in   system clock, all logic on the rising edge
//   reset   in   synchronous, active-high reset
//   c       in   ignition key contact, 1 = engine on
//   doors   in   door contacts, 1 = open
//   m       in   motion sensor, 1 = movement
//   arm     in   remote arm request, one-cycle pulse
//   disarm  in   remote disarm request, one-cycle pulse
//   a       out  siren drive (registered)
//   armed   out  status LED, system armed (registered)
//   mem     out  alarm-memory LED, alarm fired since last arm (registered)
//   state   out  current state code, for debug
//
// State codes: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, HOLD=5.
// Codes 6 and 7 are unreachable and fall back to DISARMED.
// ---------------------------------------------------------------------------
module alarma_seq #(
    parameter int NDOORS      = 4,
    parameter int EXIT_DELAY  = 20,
    parameter int ENTRY_DELAY = 10,
    parameter int SIREN_TIME  = 30,
    parameter int CW          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c,
    input  logic [NDOORS-1:0] doors,
    input  logic              m,
    input  logic              arm,
    input  logic              disarm,
    output logic              a,
    output logic              armed,
    output logic              mem,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4,
        ST_HOLD     = 3'd5
    } state_t;

    // Timer reload values: a state that must last N cycles loads N-1 and
    // leaves on the edge where the timer is observed at zero.
    localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_DELAY - 1);
    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DELAY - 1);
    localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_TIME - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       timer_q;
    logic [CW-1:0]       timer_d;
    logic [NDOORS-1:0]   doors_q;
    logic                c_q;
    logic                mem_d;

    logic                door_trig;
    logic                mot_trig;
    logic                key_trig;
    logic                timer_zero;

    // Door triggers are edge based so a door left open while arming never
    // fires by its level alone; motion is level based.
    assign door_trig  = |(doors & ~doors_q);
    assign mot_trig   = m;
    assign key_trig   = c & ~c_q;
    assign timer_zero = (timer_q == '0);

    // -----------------------------------------------------------------------
    // Next-state, timer and alarm-memory logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        mem_d   = mem;

        if (disarm && (state_q != ST_DISARMED)) begin
            // Disarm outranks arm and every trigger; the memory LED stays
            // lit so the owner can see that something happened.
            state_d = ST_DISARMED;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    timer_d = '0;
                    // Arming with the key on is refused; arm together with
                    // disarm is treated as a disarm and also refused.
                    if (arm && !c && !disarm) begin
                        state_d = ST_EXIT;
                        timer_d = EXIT_LOAD;
                        mem_d   = 1'b0;
                    end
                end

                ST_EXIT: begin
                    // Triggers are ignored while the owner walks away.
                    if (timer_zero) begin
                        state_d = ST_ARMED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - CW'(1);
                    end
                end

                ST_ARMED: begin
                    if (mot_trig) begin
                        state_d = ST_ALARM;
                        timer_d = SIREN_LOAD;
                    end else if (door_trig || key_trig) begin
                        state_d = ST_ENTRY;
                        timer_d = ENTRY_LOAD;
                    end
                end

                ST_ENTRY: begin
                    // Motion skips the remaining grace period; further door
                    // edges do not restart it.
                    if (mot_trig || timer_zero) begin
                        state_d = ST_ALARM;
                        timer_d = SIREN_LOAD;
                    end else begin
                        timer_d = timer_q - CW'(1);
                    end
                end

                ST_ALARM: begin
                    // The siren runs for a fixed time; triggers do not
                    // extend it.
                    if (timer_zero) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - CW'(1);
                    end
                end

                ST_HOLD: begin
                    if (door_trig || mot_trig) begin
                        state_d = ST_ALARM;
                        timer_d = SIREN_LOAD;
                    end
                end

                default: begin
                    state_d = ST_DISARMED;
                    timer_d = '0;
                end
            endcase
        end

        // Any entry into ALARM (from ARMED, ENTRY or HOLD) lights the memory.
        if ((state_d == ST_ALARM) && (state_q != ST_ALARM)) begin
            mem_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DISARMED;
            timer_q <= '0;
            doors_q <= '0;
            c_q     <= 1'b0;
            a       <= 1'b0;
            armed   <= 1'b0;
            mem     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            doors_q <= doors;
            c_q     <= c;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state register.
            a       <= (state_d == ST_ALARM);
            armed   <= (state_d == ST_ARMED) || (state_d == ST_ENTRY) ||
                       (state_d == ST_ALARM) || (state_d == ST_HOLD);
            mem     <= mem_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarma_seq.sv
// ---------------------------------------------------------------------------
// tb_alarma_seq -- directed self-checking bench for alarma_seq
//
// Runs the controller with its default parameters. Inputs change 1 ns after
// a rising edge and outputs are sampled at the same point, away from the
// edge. Each snapshot compares {state, a, armed, mem} against a
// hand-computed constant.
// ---------------------------------------------------------------------------
module tb_alarma_seq;

    localparam int NDOORS      = 4;
    localparam int EXIT_DELAY  = 20;
    localparam int ENTRY_DELAY = 10;
    localparam int SIREN_TIME  = 30;
    localparam int CW          = 8;

    // Expected snapshots {state[2:0], a, armed, mem}
    localparam logic [5:0] S_DIS      = {3'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [5:0] S_DIS_MEM  = {3'd0, 1'b0, 1'b0, 1'b1};
    localparam logic [5:0] S_EXIT     = {3'd1, 1'b0, 1'b0, 1'b0};
    localparam logic [5:0] S_ARMED    = {3'd2, 1'b0, 1'b1, 1'b0};
    localparam logic [5:0] S_ENTRY    = {3'd3, 1'b0, 1'b1, 1'b0};
    localparam logic [5:0] S_ALARM    = {3'd4, 1'b1, 1'b1, 1'b1};
    localparam logic [5:0] S_HOLD     = {3'd5, 1'b0, 1'b1, 1'b1};

    logic              clk;
    logic              reset;
    logic              c;
    logic [NDOORS-1:0] doors;
    logic              m;
    logic              arm;
    logic              disarm;
    logic              a;
    logic              armed;
    logic              mem;
    logic [2:0]        state;

    int vectors;
    int miscompares;

    alarma_seq #(
        .NDOORS      (NDOORS),
        .EXIT_DELAY  (EXIT_DELAY),
        .ENTRY_DELAY (ENTRY_DELAY),
        .SIREN_TIME  (SIREN_TIME),
        .CW          (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .c      (c),
        .doors  (doors),
        .m      (m),
        .arm    (arm),
        .disarm (disarm),
        .a      (a),
        .armed  (armed),
        .mem    (mem),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted arm followed by the full exit delay; ends in ARMED.
    task automatic go_armed();
        c   = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (EXIT_DELAY) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
    endtask

    // Refused arm with key on; accepted arm, exit delay length, triggers
    // ignored during EXIT.
    task automatic test_arm();
        c   = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL arm_key_on: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
        c   = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < EXIT_DELAY; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_EXIT) begin
                miscompares++;
                $display("FAIL exit_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_EXIT);
            end
            m = (i == 5);
            if (i == 7) doors = 4'b0001;
            tick();
        end
        m = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_ARMED) begin
            miscompares++;
            $display("FAIL exit_to_armed: got %b expected %b", {state, a, armed, mem}, S_ARMED);
        end
        doors = 4'b0000;
        tick();
        vectors++;
        if ({state, a, armed, mem} !== S_ARMED) begin
            miscompares++;
            $display("FAIL door_close_armed: got %b expected %b", {state, a, armed, mem}, S_ARMED);
        end
    endtask

    // Door 2 rises in ARMED: entry delay, siren length, then HOLD.
    task automatic test_entry_siren();
        doors = 4'b0100;
        tick();
        for (int i = 0; i < ENTRY_DELAY; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_ENTRY) begin
                miscompares++;
                $display("FAIL entry_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_ENTRY);
            end
            tick();
        end
        for (int i = 0; i < SIREN_TIME; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_ALARM) begin
                miscompares++;
                $display("FAIL siren_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_ALARM);
            end
            tick();
        end
        vectors++;
        if ({state, a, armed, mem} !== S_HOLD) begin
            miscompares++;
            $display("FAIL siren_to_hold: got %b expected %b", {state, a, armed, mem}, S_HOLD);
        end
    endtask

    // In HOLD: a closing door is not a trigger, a new door edge re-fires.
    task automatic test_hold_retrigger();
        doors = 4'b0000;
        tick();
        vectors++;
        if ({state, a, armed, mem} !== S_HOLD) begin
            miscompares++;
            $display("FAIL hold_door_close: got %b expected %b", {state, a, armed, mem}, S_HOLD);
        end
        doors = 4'b0001;
        tick();
        for (int i = 0; i < SIREN_TIME; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_ALARM) begin
                miscompares++;
                $display("FAIL hold_refire_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_ALARM);
            end
            tick();
        end
        vectors++;
        if ({state, a, armed, mem} !== S_HOLD) begin
            miscompares++;
            $display("FAIL hold_refire_end: got %b expected %b", {state, a, armed, mem}, S_HOLD);
        end
    endtask

    // Disarm during the entry delay: siren never sounds, mem stays clear.
    task automatic test_entry_disarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS_MEM) begin
            miscompares++;
            $display("FAIL disarm_keeps_mem: got %b expected %b", {state, a, armed, mem}, S_DIS_MEM);
        end
        doors = 4'b0000;
        go_armed();
        vectors++;
        if ({state, a, armed, mem} !== S_ARMED) begin
            miscompares++;
            $display("FAIL rearm_clears_mem: got %b expected %b", {state, a, armed, mem}, S_ARMED);
        end
        doors = 4'b0001;
        tick();
        repeat (4) tick();
        vectors++;
        if ({state, a, armed, mem} !== S_ENTRY) begin
            miscompares++;
            $display("FAIL entry_before_disarm: got %b expected %b", {state, a, armed, mem}, S_ENTRY);
        end
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        for (int i = 0; i < ENTRY_DELAY + 2; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_DIS) begin
                miscompares++;
                $display("FAIL entry_disarm_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_DIS);
            end
            tick();
        end
    endtask

    // Motion in ARMED fires at once; extra motion mid-siren does not extend;
    // a door edge in HOLD fires again.
    task automatic test_motion();
        doors = 4'b0000;
        go_armed();
        m = 1'b1;
        tick();
        m = 1'b0;
        for (int i = 0; i < SIREN_TIME; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_ALARM) begin
                miscompares++;
                $display("FAIL motion_siren_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_ALARM);
            end
            m = (i == 10);
            tick();
        end
        m = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_HOLD) begin
            miscompares++;
            $display("FAIL motion_siren_end: got %b expected %b", {state, a, armed, mem}, S_HOLD);
        end
        doors = 4'b1000;
        tick();
        repeat (SIREN_TIME - 1) tick();
        vectors++;
        if ({state, a, armed, mem} !== S_ALARM) begin
            miscompares++;
            $display("FAIL hold_door_last_siren: got %b expected %b", {state, a, armed, mem}, S_ALARM);
        end
        tick();
        vectors++;
        if ({state, a, armed, mem} !== S_HOLD) begin
            miscompares++;
            $display("FAIL hold_door_siren_end: got %b expected %b", {state, a, armed, mem}, S_HOLD);
        end
    endtask

    // Door held open throughout arming never triggers; disarm beats a
    // simultaneous door edge.
    task automatic test_door_held();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        doors = 4'b0010;
        tick();
        go_armed();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({state, a, armed, mem} !== S_ARMED) begin
                miscompares++;
                $display("FAIL door_held_cycle_%0d: got %b expected %b", i, {state, a, armed, mem}, S_ARMED);
            end
            tick();
        end
        doors  = 4'b0110;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        doors  = 4'b0000;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL disarm_with_door: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
    endtask

    // arm+disarm together, arm outside DISARMED, key rising edge in ARMED.
    task automatic test_ignition();
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL arm_and_disarm: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
        go_armed();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_ARMED) begin
            miscompares++;
            $display("FAIL arm_while_armed: got %b expected %b", {state, a, armed, mem}, S_ARMED);
        end
        c = 1'b1;
        tick();
        vectors++;
        if ({state, a, armed, mem} !== S_ENTRY) begin
            miscompares++;
            $display("FAIL key_edge_entry: got %b expected %b", {state, a, armed, mem}, S_ENTRY);
        end
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        c      = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL key_entry_disarm: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
    endtask

    // Reset in the middle of a siren clears everything on the next edge.
    task automatic test_reset_mid_alarm();
        go_armed();
        m = 1'b1;
        tick();
        m = 1'b0;
        repeat (5) tick();
        vectors++;
        if ({state, a, armed, mem} !== S_ALARM) begin
            miscompares++;
            $display("FAIL pre_reset_alarm: got %b expected %b", {state, a, armed, mem}, S_ALARM);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL reset_mid_alarm: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
        tick();
        vectors++;
        if ({state, a, armed, mem} !== S_DIS) begin
            miscompares++;
            $display("FAIL after_reset_idle: got %b expected %b", {state, a, armed, mem}, S_DIS);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        c      = 1'b0;
        doors  = '0;
        m      = 1'b0;
        arm    = 1'b0;
        disarm = 1'b0;

        test_reset();
        test_arm();
        test_entry_siren();
        test_hold_retrigger();
        test_entry_disarm();
        test_motion();
        test_door_held();
        test_ignition();
        test_reset_mid_alarm();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d vectors expected completion", vectors);
        $fatal(1, "timeout");
    end

endmodule
